// File: rtl/axi4lite_master_pkg.sv
// Shared AXI4-Lite widths, response codes and protection default
// used by the on-chip AXI4-Lite initiator.
package axi4lite_master_pkg;

    localparam int AXI_ADDR_WIDTH   = 32;
    localparam int AXI_DATA_WIDTH   = 32;
    localparam int AXI_STROBE_WIDTH = AXI_DATA_WIDTH / 8;
    localparam int AXI_RESP_WIDTH   = 2;
    localparam int AXI_PROT_WIDTH   = 3;

    typedef logic [AXI_RESP_WIDTH-1:0] resp_t;

    localparam resp_t AXI_RESP_OKAY   = 2'b00;
    localparam resp_t AXI_RESP_EXOKAY = 2'b01;
    localparam resp_t AXI_RESP_SLVERR = 2'b10;
    localparam resp_t AXI_RESP_DECERR = 2'b11;

    localparam logic [AXI_PROT_WIDTH-1:0] AXI_PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/axi4lite_master_if.sv
// AXI4-Lite bus bundle with master and slave views.
interface axi4lite_master_if
    import axi4lite_master_pkg::*;
#(
    parameter int ADDR_W = AXI_ADDR_WIDTH,
    parameter int DATA_W = AXI_DATA_WIDTH,
    parameter int STRB_W = DATA_W / 8
) ();

    logic                      awvalid;
    logic                      awready;
    logic [ADDR_W-1:0]         awaddr;
    logic [AXI_PROT_WIDTH-1:0] awprot;
    logic                      wvalid;
    logic                      wready;
    logic [DATA_W-1:0]         wdata;
    logic [STRB_W-1:0]         wstrb;
    logic                      bvalid;
    logic                      bready;
    resp_t                     bresp;
    logic                      arvalid;
    logic                      arready;
    logic [ADDR_W-1:0]         araddr;
    logic [AXI_PROT_WIDTH-1:0] arprot;
    logic                      rvalid;
    logic                      rready;
    logic [DATA_W-1:0]         rdata;
    resp_t                     rresp;

    modport master (
        output awvalid, awaddr, awprot,
        output wvalid, wdata, wstrb,
        output bready,
        output arvalid, araddr, arprot,
        output rready,
        input  awready, wready,
        input  bvalid, bresp,
        input  arready,
        input  rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, awprot,
        input  wvalid, wdata, wstrb,
        input  bready,
        input  arvalid, araddr, arprot,
        input  rready,
        output awready, wready,
        output bvalid, bresp,
        output arready,
        output rvalid, rdata, rresp
    );

endinterface

// File: rtl/axi4lite_master.sv
// Single-outstanding command/response to AXI4-Lite initiator
// with registered bus outputs and a sticky phase watchdog.
module axi4lite_master
    import axi4lite_master_pkg::*;
#(
    parameter int ADDR_W  = AXI_ADDR_WIDTH,
    parameter int DATA_W  = AXI_DATA_WIDTH,
    parameter int STRB_W  = AXI_STROBE_WIDTH,
    parameter int TIMEOUT = 1024
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic [STRB_W-1:0] cmd_wstrb,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_write,
    output logic [DATA_W-1:0] rsp_rdata,
    output resp_t             rsp_resp,
    output logic              timeout,
    axi4lite_master_if.master m_axi
);

    typedef enum logic [2:0] {
        IDLE, WRITE, WRESP, RADDR, RDATA, RESP
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0] wstrb_q, wstrb_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    resp_t             resp_q, resp_d;
    logic              rwr_q, rwr_d;
    logic              awv_q, awv_d;
    logic              wv_q, wv_d;
    logic              arv_q, arv_d;

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
            resp_q  <= '0;
            rwr_q   <= 1'b0;
            awv_q   <= 1'b0;
            wv_q    <= 1'b0;
            arv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            rdata_q <= rdata_d;
            resp_q  <= resp_d;
            rwr_q   <= rwr_d;
            awv_q   <= awv_d;
            wv_q    <= wv_d;
            arv_q   <= arv_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        rdata_d = rdata_q;
        resp_d  = resp_q;
        rwr_d   = rwr_q;
        awv_d   = awv_q;
        wv_d    = wv_q;
        arv_d   = arv_q;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    wstrb_d = cmd_wstrb;
                    if (cmd_write) begin
                        awv_d   = 1'b1;
                        wv_d    = 1'b1;
                        state_d = WRITE;
                    end else begin
                        arv_d   = 1'b1;
                        state_d = RADDR;
                    end
                end
            end
            // AW and W complete independently, in either order
            WRITE: begin
                if (awv_q && m_axi.awready) awv_d = 1'b0;
                if (wv_q && m_axi.wready)   wv_d  = 1'b0;
                if (!awv_d && !wv_d)        state_d = WRESP;
            end
            WRESP: begin
                if (m_axi.bvalid) begin
                    resp_d  = m_axi.bresp;
                    rdata_d = '0;
                    rwr_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RADDR: begin
                if (m_axi.arready) begin
                    arv_d   = 1'b0;
                    state_d = RDATA;
                end
            end
            RDATA: begin
                if (m_axi.rvalid) begin
                    rdata_d = m_axi.rdata;
                    resp_d  = m_axi.rresp;
                    rwr_d   = 1'b0;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign cmd_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_write = rsp_valid & rwr_q;
    assign rsp_rdata = rsp_valid ? rdata_q : '0;
    assign rsp_resp  = rsp_valid ? resp_q : '0;

    assign m_axi.awvalid = awv_q;
    assign m_axi.awaddr  = awv_q ? addr_q : '0;
    assign m_axi.awprot  = AXI_PROT_DEFAULT;
    assign m_axi.wvalid  = wv_q;
    assign m_axi.wdata   = wv_q ? wdata_q : '0;
    assign m_axi.wstrb   = wv_q ? wstrb_q : '0;
    assign m_axi.bready  = (state_q == WRESP);
    assign m_axi.arvalid = arv_q;
    assign m_axi.araddr  = arv_q ? addr_q : '0;
    assign m_axi.arprot  = AXI_PROT_DEFAULT;
    assign m_axi.rready  = (state_q == RDATA);

    // Watchdog: counts cycles spent in one waiting state, saturating
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] WD_LIM = CW'(TIMEOUT);

    logic [CW-1:0] wd_cnt;
    logic          waiting;
    logic          timeout_q;

    assign waiting = state_q inside {WRITE, WRESP, RADDR, RDATA};

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            wd_cnt    <= '0;
            timeout_q <= 1'b0;
        end else if (state_d != state_q) begin
            wd_cnt <= '0;
        end else if (waiting && wd_cnt != WD_LIM) begin
            wd_cnt <= wd_cnt + 1'b1;
            if (TIMEOUT != 0 && (wd_cnt + 1'b1) == WD_LIM)
                timeout_q <= 1'b1;
        end
    end

    assign timeout = timeout_q;

endmodule

// File: tb/tb_axi4lite_master.sv
// Randomized bench for axi4lite_master: behavioural register-file
// responder, queue-based response model and per-cycle bus checks.
module tb_axi4lite_master;
  import axi4lite_master_pkg::*;

  localparam int TMO = 16;

  localparam int S_TMO  = 0;
  localparam int S_AWV  = 1;
  localparam int S_WV   = 2;
  localparam int S_ARV  = 3;
  localparam int S_BRDY = 4;
  localparam int S_RRDY = 5;
  localparam int S_RSPV = 6;
  localparam int S_CRDY = 7;
  localparam int S_RDAT = 8;
  localparam int S_BCNT = 9;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        timeout;

  always #5 CLK = ~CLK;

  axi4lite_master_if m_axi ();

  axi4lite_master #(.TIMEOUT(TMO)) dut (
    .CLK       (CLK),
    .RSTn      (RSTn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .cmd_wstrb (cmd_wstrb),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_write (rsp_write),
    .rsp_rdata (rsp_rdata),
    .rsp_resp  (rsp_resp),
    .timeout   (timeout),
    .m_axi     (m_axi.master)
  );

  typedef struct {
    bit          w;
    logic [31:0] rdata;
    logic [1:0]  resp;
    bit          lit;
    logic [31:0] lrdata;
    logic [1:0]  lresp;
  } exp_t;

  typedef struct {
    string       nm;
    int          sig;
    logic [31:0] val;
  } spot_t;

  exp_t  exp_q[$];
  spot_t spot_q[$];

  int checks = 0;
  int errors = 0;

  int cfg_aw, cfg_w, cfg_b, cfg_ar, cfg_r;
  bit cfg_ar_block;
  int n_writes;
  int b_count;

  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] slv_mem [logic [31:0]];

  function automatic logic [31:0] sig_val(int s);
    case (s)
      S_TMO:  return {31'b0, timeout};
      S_AWV:  return {31'b0, m_axi.awvalid};
      S_WV:   return {31'b0, m_axi.wvalid};
      S_ARV:  return {31'b0, m_axi.arvalid};
      S_BRDY: return {31'b0, m_axi.bready};
      S_RRDY: return {31'b0, m_axi.rready};
      S_RSPV: return {31'b0, rsp_valid};
      S_CRDY: return {31'b0, cmd_ready};
      S_RDAT: return rsp_rdata;
      S_BCNT: return 32'(b_count);
      default: return '0;
    endcase
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic spot(string nm, int s, logic [31:0] v);
    spot_t t;
    t.nm  = nm;
    t.sig = s;
    t.val = v;
    spot_q.push_back(t);
  endtask

  // Responder: register file at 0x00..0xFC, full-word writes only
  initial begin : responder
    logic        pend_aw, pend_w, pend_b, pend_ar, pend_r;
    logic        aw_got, w_got, ar_got, ok;
    logic [31:0] s_addr, s_data, s_raddr;
    logic [3:0]  s_strb;
    int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    {pend_aw, pend_w, pend_b, pend_ar, pend_r} = '0;
    {aw_got, w_got, ar_got} = '0;
    s_addr = '0; s_data = '0; s_raddr = '0; s_strb = '0;
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
    b_count = 0;
    m_axi.awready = 0; m_axi.wready = 0;
    m_axi.bvalid = 0; m_axi.bresp = '0;
    m_axi.arready = 0; m_axi.rvalid = 0;
    m_axi.rdata = '0; m_axi.rresp = '0;
    forever begin
      @(posedge CLK); #1;
      if (!RSTn) begin
        {pend_aw, pend_w, pend_b, pend_ar, pend_r} = '0;
        {aw_got, w_got, ar_got} = '0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
        b_count = 0;
        m_axi.awready = 0; m_axi.wready = 0;
        m_axi.bvalid = 0; m_axi.bresp = '0;
        m_axi.arready = 0; m_axi.rvalid = 0;
        m_axi.rdata = '0; m_axi.rresp = '0;
      end else begin
        if (pend_aw) begin aw_got = 1; m_axi.awready = 0; aw_cnt = 0; end
        if (pend_w)  begin w_got = 1;  m_axi.wready = 0;  w_cnt = 0;  end
        if (pend_b) begin
          m_axi.bvalid = 0; m_axi.bresp = '0; b_count++;
        end
        if (pend_ar) begin ar_got = 1; m_axi.arready = 0; ar_cnt = 0; end
        if (pend_r) begin
          m_axi.rvalid = 0; m_axi.rdata = '0; m_axi.rresp = '0;
        end
        if (m_axi.awvalid && !aw_got && !m_axi.awready) begin
          if (aw_cnt >= cfg_aw) m_axi.awready = 1; else aw_cnt++;
        end
        if (m_axi.wvalid && !w_got && !m_axi.wready) begin
          if (w_cnt >= cfg_w) m_axi.wready = 1; else w_cnt++;
        end
        if (aw_got && w_got && !m_axi.bvalid) begin
          if (b_cnt >= cfg_b) begin
            ok = (s_addr[1:0] == 2'b00) && (s_addr < 32'h100) &&
                 (s_strb == 4'hF);
            if (ok) slv_mem[s_addr] = s_data;
            m_axi.bvalid = 1;
            m_axi.bresp = ok ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
            aw_got = 0; w_got = 0; b_cnt = 0;
          end else b_cnt++;
        end
        if (m_axi.arvalid && !ar_got && !m_axi.arready && !cfg_ar_block) begin
          if (ar_cnt >= cfg_ar) m_axi.arready = 1; else ar_cnt++;
        end
        if (ar_got && !m_axi.rvalid) begin
          if (r_cnt >= cfg_r) begin
            ok = (s_raddr[1:0] == 2'b00) && (s_raddr < 32'h100);
            m_axi.rvalid = 1;
            m_axi.rresp = ok ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
            if (!ok) m_axi.rdata = 32'hBAD0_0000 | s_raddr;
            else if (slv_mem.exists(s_raddr)) m_axi.rdata = slv_mem[s_raddr];
            else m_axi.rdata = '0;
            ar_got = 0; r_cnt = 0;
          end else r_cnt++;
        end
        pend_aw = m_axi.awvalid && m_axi.awready;
        pend_w  = m_axi.wvalid && m_axi.wready;
        pend_b  = m_axi.bvalid && m_axi.bready;
        pend_ar = m_axi.arvalid && m_axi.arready;
        pend_r  = m_axi.rvalid && m_axi.rready;
        if (pend_aw) s_addr = m_axi.awaddr;
        if (pend_w) begin s_data = m_axi.wdata; s_strb = m_axi.wstrb; end
        if (pend_ar) s_raddr = m_axi.araddr;
      end
    end
  end

  // Compare process: spot checks, response model and bus rules
  initial begin : compare
    logic        p_ok, p_awv, p_awr, p_wv, p_wr, p_arv, p_arr;
    logic        p_rspv, p_rspr, p_rw;
    logic [31:0] p_awaddr, p_wdata, p_araddr, p_rdata;
    logic [3:0]  p_wstrb;
    logic [1:0]  p_resp;
    spot_t       s;
    exp_t        e;
    p_ok = 0;
    {p_awv, p_awr, p_wv, p_wr, p_arv, p_arr, p_rspv, p_rspr, p_rw} = '0;
    p_awaddr = '0; p_wdata = '0; p_araddr = '0; p_rdata = '0;
    p_wstrb = '0; p_resp = '0;
    forever begin
      @(negedge CLK);
      while (spot_q.size() > 0) begin
        s = spot_q.pop_front();
        chk(s.nm, 64'(sig_val(s.sig)), 64'(s.val));
      end
      if (RSTn && p_ok) begin
        if (p_awv && !p_awr)
          chk("aw_hold", {m_axi.awvalid, m_axi.awaddr}, {1'b1, p_awaddr});
        if (p_wv && !p_wr)
          chk("w_hold", {m_axi.wvalid, m_axi.wdata, m_axi.wstrb},
              {1'b1, p_wdata, p_wstrb});
        if (p_arv && !p_arr)
          chk("ar_hold", {m_axi.arvalid, m_axi.araddr}, {1'b1, p_araddr});
        if (p_rspv && !p_rspr)
          chk("rsp_hold", {rsp_valid, rsp_write, rsp_rdata, rsp_resp},
              {1'b1, p_rw, p_rdata, p_resp});
        if (m_axi.awvalid || m_axi.arvalid)
          chk("prot", {m_axi.awprot, m_axi.arprot}, 0);
        if (rsp_valid)
          chk("rsp_quiet", {cmd_ready, m_axi.awvalid, m_axi.wvalid,
              m_axi.arvalid, m_axi.bready, m_axi.rready}, 0);
        if (rsp_valid && rsp_ready) begin
          if (exp_q.size() == 0) chk("rsp_unexpected", 1, 0);
          else begin
            e = exp_q.pop_front();
            chk("rsp_model", {rsp_write, rsp_rdata, rsp_resp},
                {e.w, e.rdata, e.resp});
            if (e.lit)
              chk("rsp_literal", {rsp_rdata, rsp_resp}, {e.lrdata, e.lresp});
          end
        end
      end
      p_ok = RSTn;
      p_awv = m_axi.awvalid; p_awr = m_axi.awready; p_awaddr = m_axi.awaddr;
      p_wv = m_axi.wvalid; p_wr = m_axi.wready;
      p_wdata = m_axi.wdata; p_wstrb = m_axi.wstrb;
      p_arv = m_axi.arvalid; p_arr = m_axi.arready; p_araddr = m_axi.araddr;
      p_rspv = rsp_valid; p_rspr = rsp_ready; p_rw = rsp_write;
      p_rdata = rsp_rdata; p_resp = rsp_resp;
    end
  end

  task automatic issue(bit w, logic [31:0] a, logic [31:0] d,
                       logic [3:0] st, bit lit, logic [31:0] lrd,
                       logic [1:0] lrs, bit track);
    exp_t e;
    bit   ok;
    int   n;
    e.w = w; e.lit = lit; e.lrdata = lrd; e.lresp = lrs;
    if (w) begin
      ok = (a % 4 == 0) && (a < 256) && (st == 4'hF);
      if (ok) ref_mem[a] = d;
      e.rdata = 0;
      e.resp = ok ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
      n_writes++;
    end else begin
      ok = (a % 4 == 0) && (a < 256);
      e.resp = ok ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
      if (!ok) e.rdata = 32'hBAD0_0000 + a;
      else e.rdata = ref_mem.exists(a) ? ref_mem[a] : 0;
    end
    if (track) exp_q.push_back(e);
    cmd_valid = 1; cmd_write = w;
    cmd_addr = a; cmd_wdata = d; cmd_wstrb = st;
    n = 0;
    while (!cmd_ready && n < 50) begin @(posedge CLK); #1; n++; end
    if (!cmd_ready) begin
      spot("cmd_accept_timeout", -1, 1);
      cmd_valid = 0;
      return;
    end
    @(posedge CLK); #1;
    cmd_valid = 0; cmd_write = 0;
    cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
  endtask

  task automatic finish(int hold);
    int n;
    n = 0;
    while (!rsp_valid && n < 100) begin @(posedge CLK); #1; n++; end
    if (!rsp_valid) begin
      spot("rsp_wait_timeout", -1, 1);
      return;
    end
    repeat (hold) begin @(posedge CLK); #1; end
    rsp_ready = 1;
    @(posedge CLK); #1;
    rsp_ready = 0;
  endtask

  task automatic xact(bit w, logic [31:0] a, logic [31:0] d,
                      logic [3:0] st, bit lit, logic [31:0] lrd,
                      logic [1:0] lrs, int hold);
    issue(w, a, d, st, lit, lrd, lrs, 1);
    finish(hold);
  endtask

  initial begin : main
    logic [31:0] a;
    int          r;
    RSTn = 0; cmd_valid = 0; cmd_write = 0;
    cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 0;
    cfg_aw = 0; cfg_w = 0; cfg_b = 0; cfg_ar = 0; cfg_r = 0;
    cfg_ar_block = 0; n_writes = 0;
    repeat (3) @(posedge CLK);
    #1;
    spot("rst_awvalid", S_AWV, 0);
    spot("rst_wvalid", S_WV, 0);
    spot("rst_arvalid", S_ARV, 0);
    spot("rst_rsp_valid", S_RSPV, 0);
    spot("rst_timeout", S_TMO, 0);
    spot("rst_cmd_ready", S_CRDY, 1);
    RSTn = 1;
    @(posedge CLK); #1;

    xact(1, 32'h4, 32'hDEADBEEF, 4'hF, 1, 32'h0, AXI_RESP_OKAY, 0);
    xact(0, 32'h4, 32'h0, 4'h0, 1, 32'hDEADBEEF, AXI_RESP_OKAY, 0);

    xact(1, 32'h8, 32'hFFFFFFFF, 4'hF, 1, 32'h0, AXI_RESP_OKAY, 0);
    xact(1, 32'h8, 32'h00AA5500, 4'b0110, 1, 32'h0, AXI_RESP_SLVERR, 0);
    xact(0, 32'h8, 32'h0, 4'h0, 1, 32'hFFFFFFFF, AXI_RESP_OKAY, 0);

    xact(1, 32'h22, 32'h12345678, 4'hF, 1, 32'h0, AXI_RESP_SLVERR, 0);
    xact(0, 32'h22, 32'h0, 4'h0, 1, 32'hBAD00022, AXI_RESP_SLVERR, 0);

    cfg_aw = 0; cfg_w = 4; cfg_b = 1;
    issue(1, 32'h10, 32'hA5A5_0F0F, 4'hF, 1, 32'h0, AXI_RESP_OKAY, 1);
    @(posedge CLK); #1;
    spot("aw_drops_alone", S_AWV, 0);
    spot("w_still_valid", S_WV, 1);
    finish(0);
    cfg_aw = 4; cfg_w = 0;
    issue(1, 32'h14, 32'h0F0F_A5A5, 4'hF, 1, 32'h0, AXI_RESP_OKAY, 1);
    @(posedge CLK); #1;
    spot("aw_still_valid", S_AWV, 1);
    spot("w_drops_alone", S_WV, 0);
    finish(0);
    xact(0, 32'h10, 32'h0, 4'h0, 1, 32'hA5A5_0F0F, AXI_RESP_OKAY, 0);
    xact(0, 32'h14, 32'h0, 4'h0, 1, 32'h0F0F_A5A5, AXI_RESP_OKAY, 0);
    spot("b_handshakes", S_BCNT, 32'(n_writes));

    cfg_aw = 1; cfg_w = 1; cfg_b = 0;
    xact(1, 32'h20, 32'h1357_9BDF, 4'hF, 0, 0, 0, 5);
    xact(0, 32'h20, 32'h0, 4'h0, 0, 0, 0, 5);

    for (int i = 0; i < 40; i++) begin
      cfg_aw = $urandom_range(0, 3); cfg_w = $urandom_range(0, 3);
      cfg_b = $urandom_range(0, 3); cfg_ar = $urandom_range(0, 3);
      cfg_r = $urandom_range(0, 3);
      r = $urandom_range(0, 9);
      if (r < 7) a = 32'($urandom_range(0, 15)) << 2;
      else if (r == 7) a = (32'($urandom_range(0, 15)) << 2) | 32'h1;
      else a = 32'h100 + (32'($urandom_range(0, 15)) << 2);
      xact(1'($urandom_range(0, 1)), a, $urandom,
           ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF,
           0, 0, 0, $urandom_range(0, 3));
    end
    spot("b_handshakes_total", S_BCNT, 32'(n_writes));
    spot("no_timeout_yet", S_TMO, 0);

    cfg_ar = 0; cfg_ar_block = 1;
    issue(0, 32'h4, 32'h0, 4'h0, 0, 0, 0, 0);
    repeat (15) begin @(posedge CLK); #1; end
    spot("tmo_before", S_TMO, 0);
    spot("arvalid_waiting", S_ARV, 1);
    @(posedge CLK); #1;
    spot("tmo_at_limit", S_TMO, 1);
    spot("arvalid_held", S_ARV, 1);
    repeat (4) begin @(posedge CLK); #1; end
    spot("tmo_sticky", S_TMO, 1);

    RSTn = 0;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    spot("rst2_arvalid", S_ARV, 0);
    spot("rst2_timeout", S_TMO, 0);
    spot("rst2_rsp_valid", S_RSPV, 0);
    spot("rst2_bready", S_BRDY, 0);
    spot("rst2_rready", S_RRDY, 0);
    spot("rst2_rsp_rdata", S_RDAT, 0);
    spot("rst2_cmd_ready", S_CRDY, 1);
    RSTn = 1;
    cfg_ar_block = 0;
    repeat (3) begin @(posedge CLK); #1; end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
